// File: rtl/requant_rr_scheduler.sv
// requant_rr_scheduler
//   Round-robin arbiter feeding a two-stage requantisation pipeline. Stage A
//   rounds the selected sample (round-half-to-even, right shift by the active
//   fraction length). Stage B saturates the result to OUT_WLEN bits and
//   presents it on a valid/ready output. Configuration changes are queued and
//   applied only once the pipeline is empty.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/ready/data     per-requester input handshake, packed samples
//   cfg_load/flen/signed     configuration request; cfg_busy while pending
//   out_valid/ready/data     result handshake
//   out_id, out_sat          source requester and saturation flag of out_data
//   sat_count, sat_clr       saturating count of delivered saturated results

module requant_rr_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IN_WLEN  = 16,
  parameter int unsigned OUT_WLEN = 12,
  parameter int unsigned FLEN_W   = 4,
  localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*IN_WLEN-1:0] req_data,
  input  logic                       cfg_load,
  input  logic [FLEN_W-1:0]          cfg_flen,
  input  logic                       cfg_signed,
  output logic                       cfg_busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WLEN-1:0]        out_data,
  output logic [IdW-1:0]             out_id,
  output logic                       out_sat,
  output logic [15:0]                sat_count,
  input  logic                       sat_clr
);

  // One guard bit above the input keeps the rounding increment from overflowing.
  localparam int unsigned AW   = IN_WLEN + 1;
  localparam int unsigned SumW = IdW + 1;

  localparam logic [AW-1:0] SMax = AW'((1 << (OUT_WLEN - 1)) - 1);
  localparam logic [AW-1:0] SMin = ~SMax;
  localparam logic [AW-1:0] UMax = AW'((1 << OUT_WLEN) - 1);

  // Architectural state
  logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                a_valid_q, a_valid_d;
  logic [IdW-1:0]      a_id_q;
  logic [AW-1:0]       a_val_q;
  logic                a_signed_q;
  logic                out_valid_q, out_valid_d;
  logic [OUT_WLEN-1:0] out_data_q;
  logic [IdW-1:0]      out_id_q;
  logic                out_sat_q;
  logic [15:0]         sat_count_q, sat_count_d;
  logic [FLEN_W-1:0]   act_flen_q, pend_flen_q;
  logic                act_signed_q, pend_signed_q;
  logic                pend_q;

  // Handshake and arbitration
  logic                b_adv, a_free, accept, pipe_empty;
  logic                grant_vld;
  logic [IdW-1:0]      grant_id;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [SumW-1:0]     sum;

  assign b_adv      = !out_valid_q || out_ready;
  assign a_free     = !a_valid_q || b_adv;
  assign pipe_empty = !a_valid_q && !out_valid_q;

  // First valid requester at or above rr_ptr_q, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    sum       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + SumW'(i);
      if (sum >= SumW'(NUM_REQ)) sum = sum - SumW'(NUM_REQ);
      if (!grant_vld && req_valid[sum[IdW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = sum[IdW-1:0];
      end
    end
  end

  always_comb begin
    grant_oh           = '0;
    grant_oh[grant_id] = grant_vld;
  end

  assign req_ready = (a_free && !pend_q && rst_n) ? grant_oh : '0;
  assign accept    = |(req_ready & req_valid);

  assign rr_ptr_d = !accept                        ? rr_ptr_q :
                    (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + IdW'(1);

  // Stage A rounding of the granted sample
  logic [IN_WLEN-1:0] din;
  logic [AW-1:0]      ext, shifted, half_mask, low_mask, rounded;
  logic               rnd;
  int unsigned        f;

  assign din = req_data[int'(grant_id)*IN_WLEN +: IN_WLEN];

  always_comb begin
    f         = (int'(act_flen_q) > IN_WLEN - 1) ? IN_WLEN - 1 : int'(act_flen_q);
    ext       = act_signed_q ? {din[IN_WLEN-1], din} : {1'b0, din};
    shifted   = AW'($signed(ext) >>> f);
    half_mask = '0;
    low_mask  = '0;
    rnd       = 1'b0;
    if (f != 0) begin
      half_mask = AW'(1) << (f - 1);
      low_mask  = half_mask - AW'(1);
      // Half-to-even: round up above half, or at exactly half when odd.
      rnd = |(ext & half_mask) && (shifted[0] || |(ext & low_mask));
    end
    rounded = shifted + AW'(rnd);
  end

  // Stage B saturation of the stage A value
  logic [OUT_WLEN-1:0] sat_data;
  logic                sat_flag;

  always_comb begin
    sat_data = a_val_q[OUT_WLEN-1:0];
    sat_flag = 1'b0;
    if (a_signed_q) begin
      if ($signed(a_val_q) > $signed(SMax)) begin
        sat_data = SMax[OUT_WLEN-1:0];
        sat_flag = 1'b1;
      end else if ($signed(a_val_q) < $signed(SMin)) begin
        sat_data = SMin[OUT_WLEN-1:0];
        sat_flag = 1'b1;
      end
    end else if (a_val_q > UMax) begin
      sat_data = UMax[OUT_WLEN-1:0];
      sat_flag = 1'b1;
    end
  end

  assign a_valid_d   = accept || (a_valid_q && !b_adv);
  assign out_valid_d = b_adv ? a_valid_q : out_valid_q;

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      a_valid_q     <= 1'b0;
      a_id_q        <= '0;
      a_val_q       <= '0;
      a_signed_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_id_q      <= '0;
      out_sat_q     <= 1'b0;
      sat_count_q   <= '0;
      act_flen_q    <= '0;
      act_signed_q  <= 1'b1;
      pend_flen_q   <= '0;
      pend_signed_q <= 1'b1;
      pend_q        <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      a_valid_q   <= a_valid_d;
      out_valid_q <= out_valid_d;
      sat_count_q <= sat_count_d;
      if (accept) begin
        a_id_q     <= grant_id;
        a_val_q    <= rounded;
        a_signed_q <= act_signed_q;
      end
      if (b_adv && a_valid_q) begin
        out_data_q <= sat_data;
        out_id_q   <= a_id_q;
        out_sat_q  <= sat_flag;
      end
      // Apply the queued configuration once nothing is in flight; a cfg_load
      // on the same edge queues a fresh request behind it.
      if (pend_q && pipe_empty) begin
        act_flen_q   <= pend_flen_q;
        act_signed_q <= pend_signed_q;
        pend_q       <= 1'b0;
      end
      if (cfg_load) begin
        pend_flen_q   <= cfg_flen;
        pend_signed_q <= cfg_signed;
        pend_q        <= 1'b1;
      end
    end
  end

  assign cfg_busy  = pend_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_requant_rr_scheduler.sv
module tb_requant_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_data;
  logic        cfg_load;
  logic [3:0]  cfg_flen;
  logic        cfg_signed;
  logic        cfg_busy;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_id;
  logic        out_sat;
  logic [15:0] sat_count;
  logic        sat_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  requant_rr_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .cfg_load   (cfg_load),
    .cfg_flen   (cfg_flen),
    .cfg_signed (cfg_signed),
    .cfg_busy   (cfg_busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_sat    (out_sat),
    .sat_count  (sat_count),
    .sat_clr    (sat_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pipeline must be empty: busy for one cycle, applied on the next edge.
  task automatic load_cfg(input logic [3:0] fl, input logic sg, input string tag);
    cfg_load   = 1'b1;
    cfg_flen   = fl;
    cfg_signed = sg;
    tick();
    cfg_load = 1'b0;
    chk({tag, "_busy"}, 32'(cfg_busy), 32'd1);
    tick();
    chk({tag, "_applied"}, 32'(cfg_busy), 32'd0);
  endtask

  // Single sample through an idle pipeline with out_ready high.
  task automatic send_one(input int id, input logic [15:0] d, input logic [11:0] exp,
                          input logic exp_sat, input string tag);
    req_data[id*16 +: 16] = d;
    req_valid = 4'b0001 << id;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
    tick();
    req_valid = 4'b0000;
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    chk({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
    chk({tag, "_id"}, 32'(out_id), id);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_data   = '0;
    cfg_load   = 1'b0;
    cfg_flen   = '0;
    cfg_signed = 1'b1;
    out_ready  = 1'b1;
    sat_clr    = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    tick();

    // Rounding, signed, F=4
    load_cfg(4'd4, 1'b1, "cfg_f4");
    send_one(0, 16'h0018, 12'h002, 1'b0, "rnd_18");
    send_one(1, 16'h0028, 12'h002, 1'b0, "rnd_28");
    send_one(2, 16'h0038, 12'h004, 1'b0, "rnd_38");
    send_one(3, 16'hFFE8, 12'hFFE, 1'b0, "rnd_ffe8");

    // Saturation, signed, F=0
    load_cfg(4'd0, 1'b1, "cfg_f0");
    send_one(0, 16'h7FFF, 12'h7FF, 1'b1, "sat_pos");
    send_one(1, 16'h8000, 12'h800, 1'b1, "sat_neg");
    chk("sat_count_2", 32'(sat_count), 32'd2);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_count_clr", 32'(sat_count), 32'd0);

    // Unsigned, F=2
    load_cfg(4'd2, 1'b0, "cfg_u2");
    send_one(2, 16'hFFFE, 12'hFFF, 1'b1, "uns_fffe");
    send_one(3, 16'h0006, 12'h002, 1'b0, "uns_0006");
    chk("sat_count_1", 32'(sat_count), 32'd1);

    // Round-robin stream, signed F=0; pointer is back at 0
    load_cfg(4'd0, 1'b1, "cfg_rr");
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'h0100 + 16'(i);
    req_valid = 4'b1111;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) begin
        chk("rr_first_empty", 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("rr_id_%0d", j), 32'(out_id), (j - 2) % 4);
        chk($sformatf("rr_data_%0d", j), 32'(out_data), 32'h100 + ((j - 2) % 4));
      end
    end

    // Backpressure: both stages full, nothing may move
    out_ready = 1'b0;
    #1;
    chk("bp_ready_zero", 32'(req_ready), 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("bp_hold_id_%0d", j), 32'(out_id), 32'd0);
      chk($sformatf("bp_hold_data_%0d", j), 32'(out_data), 32'h100);
      chk($sformatf("bp_hold_valid_%0d", j), 32'(out_valid), 32'd1);
      chk($sformatf("bp_ready_%0d", j), 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk($sformatf("bp_resume_id_%0d", j), 32'(out_id), j % 4);
      if (j == 4) req_valid = 4'b0000;
    end
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Configuration change mid-stream (F=4 -> F=2), requester 2 only
    load_cfg(4'd4, 1'b1, "cfg_mid_f4");
    req_data[2*16 +: 16] = 16'h0038;
    req_valid = 4'b0100;
    tick();
    cfg_load   = 1'b1;
    cfg_flen   = 4'd2;
    cfg_signed = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("mid_busy_rise", 32'(cfg_busy), 32'd1);
    chk("mid_ready_low", 32'(req_ready), 32'd0);
    chk("mid_pre1_data", 32'(out_data), 32'h004);
    tick();
    chk("mid_pre2_valid", 32'(out_valid), 32'd1);
    chk("mid_pre2_data", 32'(out_data), 32'h004);
    chk("mid_ready_low2", 32'(req_ready), 32'd0);
    tick();
    chk("mid_drained", 32'(out_valid), 32'd0);
    chk("mid_busy_still", 32'(cfg_busy), 32'd1);
    tick();
    chk("mid_busy_clear", 32'(cfg_busy), 32'd0);
    chk("mid_ready_back", 32'(req_ready), 32'b0100);
    tick();
    chk("mid_post_lat", 32'(out_valid), 32'd0);
    tick();
    chk("mid_post_valid", 32'(out_valid), 32'd1);
    chk("mid_post_data", 32'(out_data), 32'h00E);
    req_valid = 4'b0000;
    tick();
    tick();
    tick();

    // Reset with both stages full
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'h0100 + 16'(i);
    req_valid = 4'b1111;
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_full", 32'(out_valid), 32'd1);
    chk("pre_rst_sat_count", 32'(sat_count), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_ready", 32'(req_ready), 32'd0);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_sat_count", 32'(sat_count), 32'd0);
    chk("post_rst_busy", 32'(cfg_busy), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_grant0", 32'(req_ready), 32'b0001);
    tick();
    tick();
    chk("post_rst_id", 32'(out_id), 32'd0);
    chk("post_rst_data", 32'(out_data), 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
